// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor split into STAGES carry-chain slices.
// Define ADDSUB_SAT_EN to add the sat port (signed saturation on overflow).
module pipelined_addsub #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             control,
`ifdef ADDSUB_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             overflow,
    output logic             carryOut,
    output logic             negative
);
    localparam int SW = WIDTH / STAGES;

    logic stall;
    logic sat_in;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

`ifdef ADDSUB_SAT_EN
    assign sat_in = sat;
`else
    assign sat_in = 1'b0;
`endif

    // Stage s sees only the operand slices not yet consumed (slice s at
    // bit 0) and the result slices already produced below it.
    for (genvar s = 0; s < STAGES; s++) begin : g_stg
        localparam int RW = (STAGES - s) * SW;
        localparam int DW = (s + 1) * SW;

        logic [RW-1:0] ia;
        logic [RW-1:0] ib;
        logic [DW-1:0] nr;
        logic          ic;
        logic          iv;
        logic          isat;
        logic [SW:0]   sum;

        if (s == 0) begin : g_src
            assign ia   = A;
            assign ib   = control ? ~B : B;
            assign ic   = control;
            assign iv   = in_valid;
            assign isat = sat_in;
            assign nr   = sum[SW-1:0];
        end else begin : g_src
            assign ia   = g_stg[s-1].g_q.a_q;
            assign ib   = g_stg[s-1].g_q.b_q;
            assign ic   = g_stg[s-1].g_q.c_q;
            assign iv   = g_stg[s-1].g_q.v_q;
            assign isat = g_stg[s-1].g_q.sat_q;
            assign nr   = {sum[SW-1:0], g_stg[s-1].g_q.r_q};
        end

        assign sum = {1'b0, ia[SW-1:0]} + {1'b0, ib[SW-1:0]}
                   + {{SW{1'b0}}, ic};

        if (s < STAGES - 1) begin : g_q
            logic [RW-SW-1:0] a_q;
            logic [RW-SW-1:0] b_q;
            logic [DW-1:0]    r_q;
            logic             c_q;
            logic             v_q;
            logic             sat_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    r_q   <= '0;
                    c_q   <= 1'b0;
                    v_q   <= 1'b0;
                    sat_q <= 1'b0;
                end else if (!stall) begin
                    a_q   <= ia[RW-1:SW];
                    b_q   <= ib[RW-1:SW];
                    r_q   <= nr;
                    c_q   <= sum[SW];
                    v_q   <= iv;
                    sat_q <= isat;
                end
            end
        end
    end

    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] fin;
    logic             cout;
    logic             cmsb;
    logic             ovf;
    logic             fv;
    logic             fsat;

    assign res  = g_stg[STAGES-1].nr;
    assign cout = g_stg[STAGES-1].sum[SW];
    assign fv   = g_stg[STAGES-1].iv;
    assign fsat = g_stg[STAGES-1].isat;
    // Carry into the MSB recovered from its sum bit and its operand bits.
    assign cmsb = res[WIDTH-1] ^ g_stg[STAGES-1].ia[SW-1]
                ^ g_stg[STAGES-1].ib[SW-1];
    assign ovf  = cmsb ^ cout;
    assign fin  = (fsat & ovf)
                ? {~res[WIDTH-1], {(WIDTH-1){res[WIDTH-1]}}}
                : res;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            carryOut  <= 1'b0;
            negative  <= 1'b0;
        end else if (!stall) begin
            out_valid <= fv;
            if (fv) begin
                out      <= fin;
                zero     <= (fin == '0);
                overflow <= ovf;
                carryOut <= cout;
                negative <= fin[WIDTH-1];
            end
        end
    end
endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub at WIDTH=64, STAGES=4.
// Flags, exact latency, back-pressure, mid-flight reset, optional saturation.
`timescale 1ns/1ps
module tb_pipelined_addsub;
    localparam int WIDTH  = 64;
    localparam int STAGES = 4;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             control;
`ifdef ADDSUB_SAT_EN
    logic             sat;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             overflow;
    logic             carryOut;
    logic             negative;

    int total;
    int bad;

    pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .control   (control),
`ifdef ADDSUB_SAT_EN
        .sat       (sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zero      (zero),
        .overflow  (overflow),
        .carryOut  (carryOut),
        .negative  (negative)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag,
                       input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one op right after a posedge; check exact latency and result.
    task automatic do_op(input string tag,
                         input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b,
                         input logic ctl,
                         input logic [WIDTH-1:0] eo,
                         input logic [3:0] ef);
        A        = a;
        B        = b;
        control  = ctl;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (STAGES - 2) @(posedge clk);
        #1 chk({tag, "_early"}, {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, "_out"}, out, eo);
        chk({tag, "_flags"}, {60'd0, zero, overflow, carryOut, negative},
            {60'd0, ef});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] stale;
        total     = 0;
        bad       = 0;
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        control   = 1'b0;
`ifdef ADDSUB_SAT_EN
        sat       = 1'b0;
`endif
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out", out, 64'd0);
        chk("rst_flags", {60'd0, zero, overflow, carryOut, negative}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // flags order: zero, overflow, carryOut, negative
        do_op("add_2_3", 64'd2, 64'd3, 1'b0, 64'd5, 4'b0000);
        do_op("sub_5_5", 64'd5, 64'd5, 1'b1, 64'd0, 4'b1010);
        do_op("sub_0_1", 64'd0, 64'd1, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFF, 4'b0001);
        do_op("add_max_1", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
              64'h8000_0000_0000_0000, 4'b0101);
        do_op("add_min_min", 64'h8000_0000_0000_0000,
              64'h8000_0000_0000_0000, 1'b0, 64'd0, 4'b1110);
        do_op("add_slice_carry", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0,
              64'h0000_0001_0000_0000, 4'b0000);
        do_op("sub_slice_borrow", 64'h0000_0000_0001_0000, 64'd1, 1'b1,
              64'h0000_0000_0000_FFFF, 4'b0010);

        // Back-to-back stream with a 3-cycle stall after the first result.
        fork
            begin : drv
                logic rdy;
                for (int i = 1; i <= 8; i++) begin
                    A        = 64'(i);
                    B        = 64'(10 * i);
                    control  = 1'b0;
                    in_valid = 1'b1;
                    rdy      = 1'b0;
                    for (int t = 0; t < 40 && !rdy; t++) begin
                        @(negedge clk);
                        #3 rdy = in_ready;
                        @(posedge clk);
                        #1;
                    end
                    if (!rdy) chk("stream_accept", 64'd0, 64'd1);
                end
                in_valid = 1'b0;
            end
            begin : mon
                int  got;
                int  cnt;
                bit  stalled;
                got     = 0;
                cnt     = 0;
                stalled = 1'b0;
                for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
                    @(negedge clk);
                    if (out_valid && !stalled) begin
                        stalled = 1'b1;
                        cnt     = 3;
                    end
                    if (cnt > 0) begin
                        out_ready = 1'b0;
                        #1;
                        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
                        chk("stall_valid", {63'd0, out_valid}, 64'd1);
                        chk("stall_hold", out, 64'd11);
                        cnt--;
                    end else begin
                        out_ready = 1'b1;
                        #1;
                        if (out_valid) begin
                            chk("stream_res", out, 64'(11 * (got + 1)));
                            got++;
                        end
                    end
                end
                chk("stream_count", 64'(got), 64'd8);
            end
        join
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Fill the pipe, reset mid-cycle with one result out and 3 in flight.
        A = 64'd0; B = 64'd1; control = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 A = 64'd2; B = 64'd3; control = 1'b0;
        @(posedge clk);
        #1 A = 64'd4; B = 64'd5;
        @(posedge clk);
        #1 A = 64'd6; B = 64'd7;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        chk("pre_rst_out", out, 64'hFFFF_FFFF_FFFF_FFFF);
        #3 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_out", out, 64'd0);
        chk("mid_rst_flags", {60'd0, zero, overflow, carryOut, negative},
            64'd0);
        @(posedge clk);
        @(posedge clk);
        #4 reset_n = 1'b1;
        stale = '0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("no_stale", stale, 64'd0);
        @(posedge clk);
        #1;
        do_op("post_rst", 64'd7, 64'd8, 1'b0, 64'd15, 4'b0000);

`ifdef ADDSUB_SAT_EN
        sat = 1'b1;
        do_op("sat_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
              64'h7FFF_FFFF_FFFF_FFFF, 4'b0100);
        do_op("sat_neg", 64'h8000_0000_0000_0000,
              64'h8000_0000_0000_0000, 1'b0,
              64'h8000_0000_0000_0000, 4'b0111);
        sat = 1'b0;
        do_op("nosat_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
              64'h8000_0000_0000_0000, 4'b0101);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
